id_ex_stage_reg: RTL



---
 rtl/id_ex_stage_reg.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register for the 5-stage RISC-V core. Once per rising edge
// it captures the EX/MEM/WB control bundles and the decoded operands of the
// instruction currently in ID and presents them to the EX stage. It also
// holds the load-use hazard detector and turns a load-use stall or a branch
// flush into a bubble.
//
// Optional feature macro: ID_EX_PERF_EN
//   When defined, adds bubble_cnt_o, a saturating 32-bit count of bubbles.
//   When undefined, the port and counter are absent; all else is identical.
//
// Parameters:
//   XLEN          datapath width for PC, operands and immediate
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset (state becomes a bubble)
//   EX_signal_i   EX control bundle (ALU op select)
//   MEM_signal_i  MEM control bundle: [2] Branch, [1] MemRead, [0] MemWrite
//   WB_signal_i   WB control bundle: [1] RegWrite, [0] MemtoReg
//   inst_i        instruction word in ID
//   pc_i          PC of the ID instruction
//   rs1_data_i    register-file read data, port 1
//   rs2_data_i    register-file read data, port 2
//   imm_i         sign-extended immediate
//   flush_i       branch-taken flush request for the ID instruction
//   EX_signal_o   registered EX bundle
//   MEM_signal_o  registered MEM bundle
//   WB_signal_o   registered WB bundle
//   pc_o          registered PC
//   rs1_data_o    registered rs1 data
//   rs2_data_o    registered rs2 data
//   imm_o         registered immediate
//   rs1_addr_o    registered inst[19:15]
//   rs2_addr_o    registered inst[24:20]
//   rd_addr_o     registered inst[11:7] (forced to 0 on a bubble)
//   funct_o       registered {inst[31:25], inst[14:12]}
//   stall_o       load-use hazard; PC and IF/ID must hold while high
//   bubble_cnt_o  (ID_EX_PERF_EN only) saturating bubble counter
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,

   input  logic [1:0]      EX_signal_i,
   input  logic [2:0]      MEM_signal_i,
   input  logic [1:0]      WB_signal_i,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            flush_i,

   output logic [1:0]      EX_signal_o,
   output logic [2:0]      MEM_signal_o,
   output logic [1:0]      WB_signal_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   output logic [4:0]      rd_addr_o,
   output logic [9:0]      funct_o,
   output logic            stall_o
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]     bubble_cnt_o
`endif
);

   // Field positions of the RV32 instruction word
   localparam int RS1_LSB   = 15;
   localparam int RS2_LSB   = 20;
   localparam int RD_LSB    = 7;
   localparam int F3_LSB    = 12;
   localparam int F7_LSB    = 25;

   // MemRead bit inside the MEM bundle
   localparam int MEMREAD_BIT = 1;

   // Decoded register fields of the ID instruction
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic [9:0] id_funct;

   // The opcode bits are not registered; this stage only forwards fields
   logic unused_opcode;

   // Pipeline state
   logic [1:0]      ex_d,       ex_q;
   logic [2:0]      mem_d,      mem_q;
   logic [1:0]      wb_d,       wb_q;
   logic [XLEN-1:0] pc_d,       pc_q;
   logic [XLEN-1:0] rs1_data_d, rs1_data_q;
   logic [XLEN-1:0] rs2_data_d, rs2_data_q;
   logic [XLEN-1:0] imm_d,      imm_q;
   logic [4:0]      rs1_addr_d, rs1_addr_q;
   logic [4:0]      rs2_addr_d, rs2_addr_q;
   logic [4:0]      rd_addr_d,  rd_addr_q;
   logic [9:0]      funct_d,    funct_q;

   logic            load_use;
   logic            bubble;

   assign id_rs1        = inst_i[RS1_LSB +: 5];
   assign id_rs2        = inst_i[RS2_LSB +: 5];
   assign id_rd         = inst_i[RD_LSB  +: 5];
   assign id_funct      = {inst_i[F7_LSB +: 7], inst_i[F3_LSB +: 3]};
   assign unused_opcode = ^inst_i[6:0];

   // Load-use detection looks only at the registered load in EX and the
   // instruction in ID, so flush_i has no path to stall_o. The rs2 compare
   // is done for every opcode: an occasional false stall is harmless,
   // whereas a missed one corrupts data. A load into x0 never stalls.
   always_comb begin
      load_use = 1'b0;
      if (mem_q[MEMREAD_BIT] && (rd_addr_q != 5'd0)) begin
         if ((rd_addr_q == id_rs1) || (rd_addr_q == id_rs2)) begin
            load_use = 1'b1;
         end
      end
   end

   // A stall and a flush in the same cycle still produce a single bubble;
   // the OR makes the two requests indistinguishable to the register.
   assign bubble = load_use || flush_i;

   // Next-state selection. Operand fields always follow their inputs so
   // their contents stay deterministic during a bubble; only the control
   // bundles and rd are squashed, which is what makes the slot inert.
   // Because the MEM bundle is cleared, MemRead is 0 after the bubble and
   // the stall releases by itself after exactly one cycle.
   always_comb begin
      pc_d       = pc_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      rs1_addr_d = id_rs1;
      rs2_addr_d = id_rs2;
      funct_d    = id_funct;
      ex_d       = EX_signal_i;
      mem_d      = MEM_signal_i;
      wb_d       = WB_signal_i;
      rd_addr_d  = id_rd;
      if (bubble) begin
         ex_d      = 2'b00;
         mem_d     = 3'b000;
         wb_d      = 2'b00;
         rd_addr_d = 5'd0;
      end
   end

   // Reset clears everything, which is the same as holding a bubble. A
   // bubble in flight when reset arrives is simply dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         funct_q    <= '0;
      end else begin
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         funct_q    <= funct_d;
      end
   end

   assign EX_signal_o  = ex_q;
   assign MEM_signal_o = mem_q;
   assign WB_signal_o  = wb_q;
   assign pc_o         = pc_q;
   assign rs1_data_o   = rs1_data_q;
   assign rs2_data_o   = rs2_data_q;
   assign imm_o        = imm_q;
   assign rs1_addr_o   = rs1_addr_q;
   assign rs2_addr_o   = rs2_addr_q;
   assign rd_addr_o    = rd_addr_q;
   assign funct_o      = funct_q;
   assign stall_o      = load_use;

`ifdef ID_EX_PERF_EN
   // Bubble counter: one count per edge that loads a bubble, regardless of
   // whether stall, flush or both caused it. It sticks at all-ones rather
   // than wrapping so a long run never reads as a small number.
   logic [31:0] bubble_cnt_d, bubble_cnt_q;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`else
   // Without the performance option no bubble statistics are kept.
`endif

endmodule
